// File: rtl/sad_min_search.sv
// Streaming minimum-SAD selector: scans one candidate SAD per beat over a
// GRID_X x GRID_Y window and returns the smallest SAD with its {y,x} position.
module sad_min_search #(
  parameter int unsigned SAD_W  = 12,
  parameter int unsigned GRID_X = 4,
  parameter int unsigned GRID_Y = 4,
  parameter int unsigned MV_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAD_W-1:0]    in_sad,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAD_W-1:0]    out_sad,
  output logic [2*MV_W-1:0]   out_mv,
  output logic                err
);

  localparam int unsigned   MV2_W = 2 * MV_W;
  localparam logic [MV_W-1:0] X_MAX = MV_W'(GRID_X - 1);
  localparam logic [MV_W-1:0] Y_MAX = MV_W'(GRID_Y - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [MV_W-1:0]    x;
  logic [MV_W-1:0]    y;
  logic [SAD_W-1:0]   min_sad;
  logic [MV2_W-1:0]   best;

  logic               beat_c;
  logic               win_end_c;
  logic               take_c;
  logic [SAD_W-1:0]   next_min_c;
  logic [MV2_W-1:0]   next_best_c;

  // Candidate evaluation; the first beat of a window always seeds the minimum.
  always_comb begin
    beat_c      = in_valid & in_ready;
    win_end_c   = (x == X_MAX) && (y == Y_MAX);
    take_c      = ((x == '0) && (y == '0)) || (in_sad < min_sad);
    next_min_c  = take_c ? in_sad : min_sad;
    next_best_c = take_c ? {y, x} : best;
  end

  // Window end is decided by the position count alone; in_last only feeds err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sad   <= '0;
      out_mv    <= '0;
      err       <= 1'b0;
      x         <= '0;
      y         <= '0;
      min_sad   <= '0;
      best      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ACCUM: begin
          if (beat_c) begin
            min_sad <= next_min_c;
            best    <= next_best_c;
            err     <= in_last ^ win_end_c;
            if (win_end_c) begin
              x         <= '0;
              y         <= '0;
              out_sad   <= next_min_c;
              out_mv    <= next_best_c;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else if (x == X_MAX) begin
              x <= '0;
              y <= y + MV_W'(1);
            end else begin
              x <= x + MV_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed and randomized checks of sad_min_search in the default 4x4, a 3x5
// 16-bit and a 1x1 configuration against a simple first-minimum model.
module tb_sad_min_search;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default 4x4, SAD_W=12
  logic        v, rdy, last, ov, ordy, err;
  logic [11:0] sad, osad;
  logic [7:0]  omv;
  // 3x5, SAD_W=16
  logic        v3, rdy3, last3, ov3, ordy3, err3;
  logic [15:0] sad3, osad3;
  logic [7:0]  omv3;
  // 1x1
  logic        v1, rdy1, last1, ov1, ordy1, err1;
  logic [11:0] sad1, osad1;
  logic [7:0]  omv1;

  sad_min_search u_dut (
    .clk(clk), .rst(rst), .in_valid(v), .in_ready(rdy), .in_sad(sad),
    .in_last(last), .out_valid(ov), .out_ready(ordy), .out_sad(osad),
    .out_mv(omv), .err(err));

  sad_min_search #(.SAD_W(16), .GRID_X(3), .GRID_Y(5), .MV_W(4)) u_dut35 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_sad(sad3),
    .in_last(last3), .out_valid(ov3), .out_ready(ordy3), .out_sad(osad3),
    .out_mv(omv3), .err(err3));

  sad_min_search #(.SAD_W(12), .GRID_X(1), .GRID_Y(1), .MV_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_sad(sad1),
    .in_last(last1), .out_valid(ov1), .out_ready(ordy1), .out_sad(osad1),
    .out_mv(omv1), .err(err1));

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] win[16];
  logic [15:0] win35[15];
  logic [11:0] exp_sad;
  logic [7:0]  exp_mv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: lowest raster index holding the smallest SAD.
  task automatic model4();
    int idx = 0;
    for (int i = 1; i < 16; i++)
      if (win[i] < win[idx]) idx = i;
    exp_sad = win[idx];
    exp_mv  = {4'(idx / 4), 4'(idx % 4)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_win(input int last_pos, input int max_gap);
    int g;
    model4();
    for (int i = 0; i < 16; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        v = 1'b0;
        tick();
        chk("gap_ov", ov, 0);
        chk("gap_rdy", rdy, 1);
      end
      v = 1'b1; sad = win[i]; last = (i == last_pos);
      tick();
      chk("err", err, 32'((i == last_pos) != (i == 15)));
      if (i < 15) begin
        chk("mid_ov", ov, 0);
        chk("mid_rdy", rdy, 1);
      end
    end
    v = 1'b0; last = 1'b0;
    chk("res_ov", ov, 1);
    chk("res_rdy", rdy, 0);
    chk("res_sad", osad, exp_sad);
    chk("res_mv", omv, exp_mv);
  endtask

  task automatic drain(input int hold);
    if (hold > 0) begin
      ordy = 1'b0;
      repeat (hold) begin
        tick();
        chk("hold_ov", ov, 1);
        chk("hold_rdy", rdy, 0);
        chk("hold_sad", osad, exp_sad);
        chk("hold_mv", omv, exp_mv);
      end
    end
    ordy = 1'b1;
    tick();
    chk("rel_ov", ov, 0);
    chk("rel_rdy", rdy, 1);
    ordy = 1'b0;
  endtask

  initial begin
    logic [11:0] r;
    int          idx;
    rst = 1'b1;
    v = 0; last = 0; ordy = 0; sad = '0;
    v3 = 0; last3 = 0; ordy3 = 0; sad3 = '0;
    v1 = 0; last1 = 0; ordy1 = 0; sad1 = '0;
    tick(); tick();
    chk("rst_ov", ov, 0);
    chk("rst_sad", osad, 0);
    chk("rst_mv", omv, 0);
    chk("rst_err", err, 0);
    chk("rst_ov3", ov3, 0);
    chk("rst_ov1", ov1, 0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", rdy, 1);

    // Directed minimum at index 6, then a long backpressure hold
    for (int i = 0; i < 16; i++) win[i] = 12'(200 + i);
    for (int i = 0; i < 6; i++) win[i] = 12'(100 - 10 * i);
    win[6] = 12'd5;
    run_win(15, 0);
    chk("t1_sad", osad, 5);
    chk("t1_mv", omv, 8'h12);
    drain(10);

    // All-equal window keeps the first candidate
    for (int i = 0; i < 16; i++) win[i] = 12'h0FF;
    run_win(15, 0);
    chk("tie_sad", osad, 12'h0FF);
    chk("tie_mv", omv, 8'h00);
    drain(0);

    // Repeated minimum at indices 5 and 9
    for (int i = 0; i < 16; i++) win[i] = 12'd200;
    win[5] = 12'd3; win[9] = 12'd3;
    run_win(15, 1);
    chk("tie2_sad", osad, 3);
    chk("tie2_mv", omv, 8'h11);
    drain(2);

    // Early in_last: err after beat 8 and after beat 16, result still produced
    for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(4095, 0));
    run_win(7, 0);
    drain(1);

    // Reset mid-window discards the partial minimum
    for (int i = 0; i < 7; i++) begin
      v = 1'b1; sad = (i == 3) ? 12'd1 : 12'd100; last = 1'b0;
      tick();
    end
    v = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_err", err, 0);
    chk("mrst_ov", ov, 0);
    chk("mrst_sad", osad, 0);
    rst = 1'b0;
    tick();
    chk("mrst_rdy", rdy, 1);
    for (int i = 0; i < 15; i++) win[i] = 12'(100 + i);
    win[15] = 12'd50;
    run_win(15, 0);
    chk("mrst_res_sad", osad, 50);
    chk("mrst_res_mv", omv, 8'h33);

    // Reset while holding a result
    rst = 1'b1;
    tick();
    chk("hrst_ov", ov, 0);
    chk("hrst_sad", osad, 0);
    chk("hrst_mv", omv, 0);
    rst = 1'b0;
    tick();
    chk("hrst_rdy", rdy, 1);

    // Randomized windows with gaps, early out_ready and occasional bad in_last
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 16; i++) win[i] = 12'($urandom_range(15, 0));
      ordy = $urandom_range(1, 0) != 0;
      run_win(($urandom_range(4, 0) == 0) ? int'($urandom_range(15, 0)) : 15, 2);
      drain(int'($urandom_range(3, 0)));
    end

    // 3x5, 16-bit: minimum at the last index
    for (int i = 0; i < 15; i++) begin
      v3 = 1'b1; sad3 = (i == 14) ? 16'hFFFE : 16'hFFFF; last3 = (i == 14);
      tick();
      chk("g35_err", err3, 0);
    end
    v3 = 1'b0; last3 = 1'b0;
    chk("g35_ov", ov3, 1);
    chk("g35_sad", osad3, 16'hFFFE);
    chk("g35_mv", omv3, {4'd4, 4'd2});
    ordy3 = 1'b1;
    tick();
    chk("g35_rel", rdy3, 1);
    ordy3 = 1'b0;

    // 3x5 random window
    idx = 0;
    for (int i = 0; i < 15; i++) begin
      win35[i] = 16'($urandom_range(7, 0));
      if (win35[i] < win35[idx]) idx = i;
    end
    for (int i = 0; i < 15; i++) begin
      v3 = 1'b1; sad3 = win35[i]; last3 = (i == 14);
      tick();
    end
    v3 = 1'b0; last3 = 1'b0;
    chk("g35r_ov", ov3, 1);
    chk("g35r_sad", osad3, win35[idx]);
    chk("g35r_mv", omv3, {4'(idx / 3), 4'(idx % 3)});
    ordy3 = 1'b1;
    tick();
    ordy3 = 1'b0;

    // 1x1: every beat is a window end
    for (int k = 0; k < 4; k++) begin
      r = 12'($urandom_range(4095, 0));
      v1 = 1'b1; sad1 = r; last1 = (k != 2);
      tick();
      chk("n1_ov", ov1, 1);
      chk("n1_sad", osad1, r);
      chk("n1_mv", omv1, 0);
      chk("n1_err", err1, 32'(k == 2));
      v1 = 1'b0; ordy1 = 1'b1;
      tick();
      chk("n1_rel_ov", ov1, 0);
      chk("n1_rel_rdy", rdy1, 1);
      ordy1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
# sad_min_search

Streaming minimum-SAD selector for the full-search block-matching datapath: accepts one candidate SAD per cycle over a GRID_X × GRID_Y search window, tracks the running minimum and its grid position, and presents the best SAD with its motion vector through a valid/ready handshake. It sits between the SAD accumulator array and the motion-vector writer. It generalises the fixed 16-input comparator to arbitrary SAD width and window size, with serial input, backpressure and protocol checking.

## Interface

- SAD_W, 12, unsigned SAD width
- GRID_X, 4, candidates per row (1..2^MV_W)
- GRID_Y, 4, rows per window (1..2^MV_W)
- MV_W, 4, width of each motion-vector component
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  candidate SAD present
- in_ready  out  1  block accepts a candidate this cycle
- in_sad  in  SAD_W  candidate SAD, raster order (x fastest, then y)
- in_last  in  1  producer marks final candidate of window
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_sad  out  SAD_W  minimum SAD of window
- out_mv  out  2*MV_W  {y, x} position of minimum; y in upper MV_W bits
- err  out  1  one-cycle pulse: in_last disagrees with internal count

## Operation

- N = GRID_X*GRID_Y. Beat = cycle with in_valid & in_ready.
- States: ACCUM (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
- Position counters x (0..GRID_X-1), y (0..GRID_Y-1): on each beat x increments; at x==GRID_X-1 x wraps to 0 and y increments. Counters clear on window end.
- First beat of window (x==0,y==0): min_sad <= in_sad, best <= {0,0} unconditionally.
- Later beats: if in_sad < min_sad (strict, unsigned) then min_sad <= in_sad, best <= {y,x}. Ties keep the earlier (lower raster index) candidate.
- Window end is decided by count only: beat at x==GRID_X-1 & y==GRID_Y-1. On that beat the comparison is included, out_sad/out_mv load the final result, state -> HOLD.
- HOLD: out_sad/out_mv stable; on out_ready state -> ACCUM. No input accepted in HOLD.
- Protocol check: on any beat, err pulses next cycle if in_last != (beat is window end). Block does not resynchronise on in_last; counting continues.
- N==1: every beat is a window end; out_mv = 0.
- x, y zero-extended to MV_W in out_mv.

## Timing

- Reset: state ACCUM, in_ready=1 in the cycle after rst deasserts, out_valid=0, out_sad=0, out_mv=0, err=0, x=y=0, min_sad=0.
- rst mid-window or in HOLD: partial window and held result discarded; no err pulse.
- Latency: out_valid rises the cycle after the final beat.
- Throughput: N beats + 1 hold cycle minimum per window (out_ready held high → one bubble cycle where in_ready=0).
- in_valid gaps inside a window are legal; state unchanged on non-beat cycles.
- out_ready while out_valid=0 is ignored.
- err is registered, 1 cycle wide, same cycle relation for window-end and mid-window mismatches.

## Test plan

- Defaults, 16 beats SAD = 100,90,...,then 5 at index 6 (x=2,y=1), others >5, in_last on beat 16 -> out_sad=5, out_mv=8'h12, out_valid one cycle after beat 16, err=0.
- Ties: all 16 SADs = 12'h0FF -> out_sad=12'h0FF, out_mv=8'h00; minimum 3 at indices 5 and 9 -> out_mv=8'h11.
- Backpressure: out_ready low 10 cycles after result -> in_ready=0, out_sad/out_mv stable throughout; out_ready high -> in_ready=1 next cycle, next window results independent of previous.
- Protocol: in_last on beat 8 -> err pulse after beat 8; no in_last on beat 16 -> err pulse after beat 16; result still produced after beat 16.
- Reset mid-window after 7 beats holding minimum 1 -> next full window with minimum 50 at index 15 gives out_sad=50, out_mv=8'h33.
- Parameters GRID_X=3, GRID_Y=5, SAD_W=16, minimum 16'hFFFE at last index with others 16'hFFFF -> out_mv={4'd4,4'd2}; N=1 config: each beat yields a result with out_mv=0.
